// File: rtl/ghb_checkpoint_stack_pkg.sv
// Shared types for the branch-history checkpoint store.
package ghb_checkpoint_stack_pkg;

    localparam int CKPT_GHB_W  = 8;
    localparam int CKPT_NUM_BR = 4;

    typedef logic [CKPT_NUM_BR-1:0] BMASK_t;
    typedef logic [CKPT_GHB_W-1:0]  GHBR_t;

    // One in-flight branch: liveness, fetch-time history, older live slots at allocation.
    typedef struct packed {
        logic   valid;
        GHBR_t  ghbr;
        BMASK_t dep;
    } ckpt_entry_t;

endpackage

// File: rtl/psel_lowest.sv
// One-hot picker: keeps only the lowest set bit of the request vector.
module psel_lowest #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_grant
);

    // Two's-complement trick x & -x isolates the lowest set bit; all-zero in gives zero out.
    always_comb begin
        o_grant = i_req & (~i_req + WIDTH'(1));
    end

endmodule

// File: rtl/ghb_checkpoint_stack.sv
// Per-branch global-history checkpoints with one-hot slot allocation,
// execute-time checkpoint readout and mispredict recovery/squash.
module ghb_checkpoint_stack
    import ghb_checkpoint_stack_pkg::*;
#(
    parameter int GHB_SIZE   = CKPT_GHB_W,
    parameter int NUM_BRANCH = CKPT_NUM_BR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_en,
    input  logic [GHB_SIZE-1:0]   alloc_ghbr,
    output logic                  alloc_ready,
    output logic [NUM_BRANCH-1:0] alloc_bmask,
    output logic [NUM_BRANCH-1:0] cur_bmask,
    input  logic                  resolve_en,
    input  logic [NUM_BRANCH-1:0] resolve_bmask,
    input  logic                  resolve_taken,
    input  logic                  resolve_mispredict,
    output logic [GHB_SIZE-1:0]   X_ghbr,
    output logic                  recover_en,
    output logic [GHB_SIZE-1:0]   recover_ghbr,
    output logic [NUM_BRANCH-1:0] squash_mask
);

    ckpt_entry_t r_slot [NUM_BRANCH];

    BMASK_t w_valid;
    BMASK_t w_free;
    BMASK_t w_grant;
    BMASK_t w_new_dep;
    BMASK_t w_squash;
    GHBR_t  w_ckpt;
    GHBR_t  w_x;
    logic   w_hit_any;
    logic   w_hit;
    logic   w_recover;
    logic   w_correct;
    logic   w_alloc_ready;
    logic   w_alloc_fire;

    // Gather slot liveness into a mask.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_BRANCH; i++) begin
            w_valid[i] = r_slot[i].valid;
        end
        w_free = ~w_valid;
    end

    psel_lowest #(.WIDTH(NUM_BRANCH)) u_psel_lowest (
        .i_req   (w_free),
        .o_grant (w_grant)
    );

    // One-hot AND-OR mux of the resolving slot's checkpoint, plus its liveness.
    always_comb begin
        w_ckpt    = '0;
        w_hit_any = 1'b0;
        for (int i = 0; i < NUM_BRANCH; i++) begin
            w_ckpt    = w_ckpt | (r_slot[i].ghbr & {GHB_SIZE{resolve_bmask[i]}});
            w_hit_any = w_hit_any | (resolve_bmask[i] & r_slot[i].valid);
        end
        w_x       = resolve_en ? w_ckpt : '0;
        w_hit     = resolve_en & w_hit_any;
        w_recover = w_hit & resolve_mispredict;
        w_correct = w_hit & ~resolve_mispredict;
    end

    // Squash live slots that depended on the mispredicted one; the resolved slot itself is excluded.
    always_comb begin
        w_squash = '0;
        for (int j = 0; j < NUM_BRANCH; j++) begin
            w_squash[j] = w_recover & r_slot[j].valid
                        & (|(r_slot[j].dep & resolve_bmask)) & ~resolve_bmask[j];
        end
    end

    // Allocation handshake; a mispredict blocks dispatch since that branch is younger and dies.
    always_comb begin
        w_alloc_ready = (|w_free) & ~(resolve_en & resolve_mispredict);
        w_alloc_fire  = alloc_en & w_alloc_ready;
        w_new_dep     = w_valid & ~(resolve_en & ~resolve_mispredict ? resolve_bmask : '0);
    end

    // Drive the outward-facing signals.
    always_comb begin
        alloc_ready  = w_alloc_ready;
        alloc_bmask  = w_grant;
        cur_bmask    = w_valid;
        X_ghbr       = w_x;
        recover_en   = w_recover;
        recover_ghbr = {w_x[GHB_SIZE-2:0], resolve_taken};
        squash_mask  = w_squash;
    end

    // Slot state: allocate into the granted free slot, retire/squash others, drop resolved dep bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BRANCH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BRANCH; i++) begin
                if (w_alloc_fire && w_grant[i]) begin
                    r_slot[i] <= '{valid: 1'b1, ghbr: alloc_ghbr, dep: w_new_dep};
                end else begin
                    if ((w_hit && resolve_bmask[i]) || w_squash[i]) begin
                        r_slot[i].valid <= 1'b0;
                    end
                    if (w_correct) begin
                        r_slot[i].dep <= r_slot[i].dep & ~resolve_bmask;
                    end
                end
            end
        end
    end

    // A resolving branch must name exactly one slot.
    a_resolve_onehot: assert property (@(posedge clock) disable iff (reset)
        resolve_en |-> $onehot(resolve_bmask));

endmodule

// File: tb/tb_ghb_checkpoint_stack.sv
// Scoreboard bench for ghb_checkpoint_stack: stimulus pushes expected outputs,
// a negedge monitor pops and compares. Reference model orders branches by age.
module tb_ghb_checkpoint_stack;

    logic       clock = 1'b0;
    logic       reset;
    logic       alloc_en;
    logic [7:0] alloc_ghbr;
    logic       alloc_ready;
    logic [3:0] alloc_bmask;
    logic [3:0] cur_bmask;
    logic       resolve_en;
    logic [3:0] resolve_bmask;
    logic       resolve_taken;
    logic       resolve_mispredict;
    logic [7:0] X_ghbr;
    logic       recover_en;
    logic [7:0] recover_ghbr;
    logic [3:0] squash_mask;

    always #5 clock = ~clock;

    ghb_checkpoint_stack #(.GHB_SIZE(8), .NUM_BRANCH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_en           (alloc_en),
        .alloc_ghbr         (alloc_ghbr),
        .alloc_ready        (alloc_ready),
        .alloc_bmask        (alloc_bmask),
        .cur_bmask          (cur_bmask),
        .resolve_en         (resolve_en),
        .resolve_bmask      (resolve_bmask),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .X_ghbr             (X_ghbr),
        .recover_en         (recover_en),
        .recover_ghbr       (recover_ghbr),
        .squash_mask        (squash_mask)
    );

    typedef struct {
        logic       ar;
        logic [3:0] ab;
        logic [3:0] cb;
        logic [7:0] x;
        logic       re;
        logic [7:0] rg;
        logic [3:0] sq;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: liveness, stored history, and allocation age of each slot.
    bit          m_valid [4];
    logic [7:0]  m_ghbr  [4];
    int unsigned m_age   [4];
    int unsigned m_next_age = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, expv);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    // Drive one cycle of inputs, predict outputs, advance the model, step to the next edge.
    task automatic do_cycle(input logic rst, input logic ae, input logic [7:0] ag,
                            input logic re, input logic [3:0] rb, input logic rt, input logic rm);
        exp_t e;
        int   f;
        int   idx;
        reset = rst; alloc_en = ae; alloc_ghbr = ag;
        resolve_en = re; resolve_bmask = rb; resolve_taken = rt; resolve_mispredict = rm;

        f   = lowest_free();
        idx = 0;
        for (int i = 0; i < 4; i++) if (rb[i]) idx = i;

        e.ar = (f >= 0) && !(re && rm);
        e.ab = (f >= 0) ? 4'(1 << f) : 4'b0000;
        e.cb = '0;
        for (int i = 0; i < 4; i++) e.cb[i] = m_valid[i];
        e.x  = re ? m_ghbr[idx] : 8'h00;
        e.re = re && rm && m_valid[idx];
        e.rg = {e.x[6:0], rt};
        e.sq = '0;
        if (e.re) for (int j = 0; j < 4; j++)
            if (m_valid[j] && m_age[j] > m_age[idx]) e.sq[j] = 1'b1;
        q.push_back(e);

        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_ghbr[i] = '0; m_age[i] = 0; end
        end else begin
            if (re && m_valid[idx]) begin
                m_valid[idx] = 0;
                for (int j = 0; j < 4; j++) if (e.sq[j]) m_valid[j] = 0;
            end
            if (ae && e.ar) begin
                m_valid[f] = 1; m_ghbr[f] = ag; m_age[f] = m_next_age; m_next_age++;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        do_cycle(0, 0, 8'h00, 0, 4'b0000, 0, 0);
    endtask

    task automatic alloc(input logic [7:0] g);
        do_cycle(0, 1, g, 0, 4'b0000, 0, 0);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("alloc_ready",  32'(alloc_ready),  32'(e.ar));
                check("alloc_bmask",  32'(alloc_bmask),  32'(e.ab));
                check("cur_bmask",    32'(cur_bmask),    32'(e.cb));
                check("X_ghbr",       32'(X_ghbr),       32'(e.x));
                check("recover_en",   32'(recover_en),   32'(e.re));
                check("recover_ghbr", 32'(recover_ghbr), 32'(e.rg));
                check("squash_mask",  32'(squash_mask),  32'(e.sq));
            end
        end
    end

    initial begin
        logic [3:0] rb;
        int         live[$];
        int         pick;

        reset = 1; alloc_en = 0; alloc_ghbr = '0; resolve_en = 0;
        resolve_bmask = '0; resolve_taken = 0; resolve_mispredict = 0;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_ghbr[i] = '0; m_age[i] = 0; end
        @(posedge clock); #1;

        // Reset state, fill to full, then an alloc attempt while full.
        idle();
        alloc(8'h11); alloc(8'h22); alloc(8'h33); alloc(8'h44);
        alloc(8'h99);
        // Correct resolve of slot 1, reallocate it, then mispredict slot 0 kills all younger.
        do_cycle(0, 0, 8'h00, 1, 4'b0010, 0, 0);
        alloc(8'h66);
        do_cycle(0, 0, 8'h00, 1, 4'b0001, 1, 1);
        idle();
        // Fill in order, mispredict slot 0 with taken=1.
        alloc(8'h11); alloc(8'h22); alloc(8'h33); alloc(8'h44);
        do_cycle(0, 0, 8'h00, 1, 4'b0001, 1, 1);
        idle();
        // Same-cycle alloc + correct resolve of slot 0 with slots 0,1 live.
        do_cycle(1, 0, 8'h00, 0, 4'b0000, 0, 0);
        alloc(8'h01); alloc(8'h02);
        do_cycle(0, 1, 8'h03, 1, 4'b0001, 0, 0);
        alloc(8'h04);
        do_cycle(0, 0, 8'h00, 1, 4'b0010, 0, 1);
        // Same-cycle alloc + mispredict: alloc blocked.
        alloc(8'h10); alloc(8'h20);
        do_cycle(0, 1, 8'h55, 1, 4'b0001, 1, 1);
        idle();
        // Resolve of a freed slot still reads its stored history.
        do_cycle(0, 0, 8'h00, 1, 4'b0010, 0, 1);
        // Reset with three live slots.
        alloc(8'hA1); alloc(8'hA2); alloc(8'hA3);
        do_cycle(1, 0, 8'h00, 0, 4'b0000, 0, 0);
        idle();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            live.delete();
            for (int i = 0; i < 4; i++) if (m_valid[i]) live.push_back(i);
            if (live.size() > 0 && $urandom_range(0, 9) < 8)
                pick = live[$urandom_range(0, live.size() - 1)];
            else
                pick = $urandom_range(0, 3);
            rb = 4'(1 << pick);
            do_cycle($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 6, 8'($urandom),
                     $urandom_range(0, 9) < 4, rb, 1'($urandom), $urandom_range(0, 9) < 3);
        end
        idle();

        repeat (2) @(posedge clock);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
